// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for the pipelined floating-point multiplier.
interface fp_mul_pipe_if #(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + FRC_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     fp_X;
  logic [W-1:0]     fp_Y;
  logic [2:0]       r_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     fp_Z;
  logic [TAG_W-1:0] out_tag;
  logic             ovrf;
  logic             udrf;
  logic             zer;
  logic             inf;
  logic             nan;

  modport master (
    output in_valid, fp_X, fp_Y, r_mode, in_tag, out_ready,
    input  in_ready, out_valid, fp_Z, out_tag, ovrf, udrf, zer, inf, nan
  );

  modport slave (
    input  in_valid, fp_X, fp_Y, r_mode, in_tag, out_ready,
    output in_ready, out_valid, fp_Z, out_tag, ovrf, udrf, zer, inf, nan
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-style floating-point multiplier with valid/ready flow control.
// S1 unpacks and multiplies significands, S2 normalises and rounds,
// S3 forms the exponent, resolves exceptions and packs the result.
// Subnormal inputs are flushed to zero and no subnormal output is produced.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int FRC_W = 23,
  parameter int TAG_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  fp_mul_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + FRC_W;
  localparam int SW = FRC_W + 1;
  localparam int PW = 2 * SW;

  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [EXP_W+1:0] BIAS_V = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [W-1:0]     QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRC_W-1){1'b0}}};

  logic en;

  // S1 combinational unpack
  logic [EXP_W-1:0] xExp, yExp;
  logic [FRC_W-1:0] xFrc, yFrc;
  logic             xZero, yZero, xInf, yInf, xNan, yNan;
  logic             sign_d, nan_d, inf_d, zero_d;
  logic [PW-1:0]    prod_d;

  // S1 registers
  logic             s1Valid_q, s1Sign_q, s1Nan_q, s1Inf_q, s1Zero_q;
  logic [EXP_W-1:0] s1ExpX_q, s1ExpY_q;
  logic [PW-1:0]    s1Prod_q;
  logic [2:0]       s1Rmode_q;
  logic [TAG_W-1:0] s1Tag_q;

  // S2 combinational normalise/round
  logic [PW-2:0]    shifted;
  logic [FRC_W-1:0] keptFrac;
  logic             guardBit, roundBit, stickyBit, inc;
  logic [FRC_W:0]   rounded;
  logic             normN_d, normR_d;
  logic [FRC_W-1:0] frac_d;

  // S2 registers
  logic             s2Valid_q, s2Sign_q, s2Nan_q, s2Inf_q, s2Zero_q;
  logic [EXP_W-1:0] s2ExpX_q, s2ExpY_q;
  logic             s2NormN_q, s2NormR_q;
  logic [FRC_W-1:0] s2Frac_q;
  logic [2:0]       s2Rmode_q;
  logic [TAG_W-1:0] s2Tag_q;

  // S3 combinational exponent/exception/pack
  logic [EXP_W+1:0] expSum;
  logic             expOvf, expUdf, toInf;
  logic [W-1:0]     z_d;
  logic             ovrf_d, udrf_d, zer_d, inf_d3, nan_d3;

  // Output registers
  logic             outValid_q;
  logic [W-1:0]     fpZ_q;
  logic [TAG_W-1:0] outTag_q;
  logic             ovrf_q, udrf_q, zer_q, inf_q, nan_q;

  assign en            = !outValid_q || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = outValid_q;
  assign bus.fp_Z      = fpZ_q;
  assign bus.out_tag   = outTag_q;
  assign bus.ovrf      = ovrf_q;
  assign bus.udrf      = udrf_q;
  assign bus.zer       = zer_q;
  assign bus.inf       = inf_q;
  assign bus.nan       = nan_q;

  // Classify operands (exponent 0 counts as zero) and multiply significands
  always_comb begin
    xExp   = bus.fp_X[W-2 -: EXP_W];
    yExp   = bus.fp_Y[W-2 -: EXP_W];
    xFrc   = bus.fp_X[FRC_W-1:0];
    yFrc   = bus.fp_Y[FRC_W-1:0];
    xZero  = (xExp == '0);
    yZero  = (yExp == '0);
    xInf   = (&xExp) && (xFrc == '0);
    yInf   = (&yExp) && (yFrc == '0);
    xNan   = (&xExp) && (xFrc != '0);
    yNan   = (&yExp) && (yFrc != '0);
    sign_d = bus.fp_X[W-1] ^ bus.fp_Y[W-1];
    nan_d  = xNan || yNan || (xInf && yZero) || (xZero && yInf);
    inf_d  = (xInf || yInf) && !nan_d;
    zero_d = (xZero || yZero) && !nan_d && !(xInf || yInf);
    prod_d = {{SW{1'b0}}, !xZero, xFrc} * {{SW{1'b0}}, !yZero, yFrc};
  end

  // S1 register: capture a new operation or a bubble whenever the pipe advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Sign_q  <= 1'b0;
      s1Nan_q   <= 1'b0;
      s1Inf_q   <= 1'b0;
      s1Zero_q  <= 1'b0;
      s1ExpX_q  <= '0;
      s1ExpY_q  <= '0;
      s1Prod_q  <= '0;
      s1Rmode_q <= '0;
      s1Tag_q   <= '0;
    end else if (en) begin
      s1Valid_q <= bus.in_valid;
      s1Sign_q  <= sign_d;
      s1Nan_q   <= nan_d;
      s1Inf_q   <= inf_d;
      s1Zero_q  <= zero_d;
      s1ExpX_q  <= xExp;
      s1ExpY_q  <= yExp;
      s1Prod_q  <= prod_d;
      s1Rmode_q <= bus.r_mode;
      s1Tag_q   <= bus.in_tag;
    end
  end

  // Normalise to a leading one, extract guard/round/sticky and round per mode
  always_comb begin
    normN_d   = s1Prod_q[PW-1];
    shifted   = normN_d ? s1Prod_q[PW-2:0] : {s1Prod_q[PW-3:0], 1'b0};
    keptFrac  = shifted[PW-2 -: FRC_W];
    guardBit  = shifted[FRC_W];
    roundBit  = shifted[FRC_W-1];
    stickyBit = |shifted[FRC_W-2:0];
    inc       = 1'b0;
    case (s1Rmode_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1Sign_q && (guardBit || roundBit || stickyBit);
      RM_RUP:  inc = !s1Sign_q && (guardBit || roundBit || stickyBit);
      RM_RMM:  inc = guardBit;
      default: inc = guardBit && (roundBit || stickyBit || keptFrac[0]);
    endcase
    rounded = {1'b0, keptFrac} + {{FRC_W{1'b0}}, inc};
    normR_d = rounded[FRC_W];
    frac_d  = normR_d ? '0 : rounded[FRC_W-1:0];
  end

  // S2 register: rounded fraction plus the exponent adjustments it implies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid_q <= 1'b0;
      s2Sign_q  <= 1'b0;
      s2Nan_q   <= 1'b0;
      s2Inf_q   <= 1'b0;
      s2Zero_q  <= 1'b0;
      s2ExpX_q  <= '0;
      s2ExpY_q  <= '0;
      s2NormN_q <= 1'b0;
      s2NormR_q <= 1'b0;
      s2Frac_q  <= '0;
      s2Rmode_q <= '0;
      s2Tag_q   <= '0;
    end else if (en) begin
      s2Valid_q <= s1Valid_q;
      s2Sign_q  <= s1Sign_q;
      s2Nan_q   <= s1Nan_q;
      s2Inf_q   <= s1Inf_q;
      s2Zero_q  <= s1Zero_q;
      s2ExpX_q  <= s1ExpX_q;
      s2ExpY_q  <= s1ExpY_q;
      s2NormN_q <= normN_d;
      s2NormR_q <= normR_d;
      s2Frac_q  <= frac_d;
      s2Rmode_q <= s1Rmode_q;
      s2Tag_q   <= s1Tag_q;
    end
  end

  // Exponent in two extra bits so it cannot wrap; specials beat overflow/underflow
  always_comb begin
    expSum = {2'b00, s2ExpX_q} + {2'b00, s2ExpY_q} - BIAS_V
           + {{(EXP_W+1){1'b0}}, s2NormN_q} + {{(EXP_W+1){1'b0}}, s2NormR_q};
    expOvf = !expSum[EXP_W+1] && (expSum[EXP_W:0] >= {1'b0, {EXP_W{1'b1}}});
    expUdf = expSum[EXP_W+1] || (expSum == '0);
    case (s2Rmode_q)
      RM_RTZ:  toInf = 1'b0;
      RM_RDN:  toInf = s2Sign_q;
      RM_RUP:  toInf = !s2Sign_q;
      default: toInf = 1'b1;
    endcase
    z_d    = {s2Sign_q, expSum[EXP_W-1:0], s2Frac_q};
    ovrf_d = 1'b0;
    udrf_d = 1'b0;
    zer_d  = 1'b0;
    inf_d3 = 1'b0;
    nan_d3 = 1'b0;
    if (s2Nan_q) begin
      z_d    = QNAN;
      nan_d3 = 1'b1;
    end else if (s2Inf_q) begin
      z_d    = {s2Sign_q, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
      inf_d3 = 1'b1;
    end else if (s2Zero_q) begin
      z_d    = {s2Sign_q, {(W-1){1'b0}}};
      zer_d  = 1'b1;
    end else if (expOvf) begin
      ovrf_d = 1'b1;
      if (toInf) begin
        z_d    = {s2Sign_q, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
        inf_d3 = 1'b1;
      end else begin
        z_d    = {s2Sign_q, {(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};
      end
    end else if (expUdf) begin
      z_d    = {s2Sign_q, {(W-1){1'b0}}};
      udrf_d = 1'b1;
      zer_d  = 1'b1;
    end
  end

  // Output register: holds the presented result until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      fpZ_q      <= '0;
      outTag_q   <= '0;
      ovrf_q     <= 1'b0;
      udrf_q     <= 1'b0;
      zer_q      <= 1'b0;
      inf_q      <= 1'b0;
      nan_q      <= 1'b0;
    end else if (en) begin
      outValid_q <= s2Valid_q;
      fpZ_q      <= z_d;
      outTag_q   <= s2Tag_q;
      ovrf_q     <= ovrf_d;
      udrf_q     <= udrf_d;
      zer_q      <= zer_d;
      inf_q      <= inf_d3;
      nan_q      <= nan_d3;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Randomised and directed bench for fp_mul_pipe against a plain-arithmetic reference.
module tb_fp_mul_pipe;
  localparam int EXP_W = 8;
  localparam int FRC_W = 23;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [31:0] z;
    logic [4:0]  f;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stallLo = -1;
  int   stallHi = -1;
  bit   randReady = 1'b0;
  bit   accepted = 1'b0;
  bit   sawOutValid = 1'b0;
  bit   stalledPrev = 1'b0;
  bit   useDirected = 1'b0;
  logic [31:0] dirZ;
  logic [4:0]  dirF;
  logic [31:0] heldZ;
  logic [9:0]  heldMeta;
  exp_t expQ[$];

  fp_mul_pipe_if #(.EXP_W(EXP_W), .FRC_W(FRC_W), .TAG_W(TAG_W)) bus ();

  fp_mul_pipe #(.EXP_W(EXP_W), .FRC_W(FRC_W), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case something wedges
  initial begin
    #800000;
    $display("[TB] FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
    end
  endtask

  // Reference product from the value definitions: flags are {ovrf,udrf,zer,inf,nan}
  function automatic logic [36:0] refMul(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    int ex, ey, e, shift, nn, nr;
    longint fx, fy, p, kept, rem, half;
    bit s, xz, yz, xi, yi, xn, yn, inc;
    logic [31:0] z;
    logic [4:0]  f;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = longint'(x[22:0]);
    fy = longint'(y[22:0]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (fx == 0);
    yi = (ey == 255) && (fy == 0);
    xn = (ex == 255) && (fx != 0);
    yn = (ey == 255) && (fy != 0);
    f  = 5'b00000;
    z  = 32'h0;
    if (xn || yn || (xi && yz) || (xz && yi)) begin
      z = 32'h7FC00000;
      f = 5'b00001;
    end else if (xi || yi) begin
      z = {s, 8'hFF, 23'h0};
      f = 5'b00010;
    end else if (xz || yz) begin
      z = {s, 31'h0};
      f = 5'b00100;
    end else begin
      p = (fx + (longint'(1) << 23)) * (fy + (longint'(1) << 23));
      if (p >= (longint'(1) << 47)) begin
        nn = 1;
        shift = 24;
      end else begin
        nn = 0;
        shift = 23;
      end
      kept = p >> shift;
      rem  = p - (kept << shift);
      half = longint'(1) << (shift - 1);
      case (rm)
        3'd1:    inc = 1'b0;
        3'd2:    inc = s && (rem != 0);
        3'd3:    inc = !s && (rem != 0);
        3'd4:    inc = (rem >= half);
        default: inc = (rem > half) || ((rem == half) && kept[0]);
      endcase
      kept = kept + longint'(inc);
      nr = 0;
      if (kept == (longint'(1) << 24)) begin
        kept = longint'(1) << 23;
        nr = 1;
      end
      e = ex + ey - 127 + nn + nr;
      if (e >= 255) begin
        if (rm == 3'd1 || (rm == 3'd2 && !s) || (rm == 3'd3 && s)) begin
          z = {s, 8'hFE, 23'h7FFFFF};
          f = 5'b10000;
        end else begin
          z = {s, 8'hFF, 23'h0};
          f = 5'b10010;
        end
      end else if (e <= 0) begin
        z = {s, 31'h0};
        f = 5'b01100;
      end else begin
        z = {s, 8'(e), kept[22:0]};
      end
    end
    return {f, z};
  endfunction

  function automatic logic [31:0] genOperand();
    int kind;
    logic [7:0]  e;
    logic [22:0] f;
    logic        s;
    kind = int'($urandom_range(0, 11));
    s = 1'($urandom);
    f = 23'($urandom);
    case (kind)
      0: e = 8'h00;
      1: begin e = 8'hFF; f = '0; end
      2: begin e = 8'hFF; f[22] = 1'b1; end
      3: e = 8'($urandom_range(200, 254));
      4: e = 8'($urandom_range(1, 60));
      5: begin e = 8'($urandom_range(100, 150)); f = 23'($urandom_range(0, 3)); end
      6: begin e = 8'($urandom_range(100, 150)); f = 23'h7FFFFF - 23'($urandom_range(0, 3)); end
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {s, e, f};
  endfunction

  // One clock: drive out_ready, observe both handshakes at the falling edge, advance
  task automatic runCycle();
    logic [36:0] r;
    exp_t        ent;
    logic [4:0]  flags;
    if (cyc >= stallLo && cyc <= stallHi) bus.out_ready = 1'b0;
    else if (randReady)                  bus.out_ready = ($urandom_range(0, 3) != 0);
    else                                 bus.out_ready = 1'b1;
    @(negedge clk);
    flags       = {bus.ovrf, bus.udrf, bus.zer, bus.inf, bus.nan};
    accepted    = bus.in_valid && bus.in_ready;
    sawOutValid = bus.out_valid;
    if (stalledPrev) begin
      checkOutput("hold_z", 64'(bus.fp_Z), 64'(heldZ));
      checkOutput("hold_meta", 64'({bus.out_valid, bus.out_tag, flags}), 64'(heldMeta));
    end
    if (bus.out_valid && !bus.out_ready) begin
      checkOutput("in_ready_stall", 64'(bus.in_ready), 64'(0));
      stalledPrev = 1'b1;
      heldZ       = bus.fp_Z;
      heldMeta    = {bus.out_valid, bus.out_tag, flags};
    end else begin
      stalledPrev = 1'b0;
    end
    if (!bus.out_valid) checkOutput("in_ready_idle", 64'(bus.in_ready), 64'(1));
    if (accepted) begin
      if (useDirected) begin
        ent.z = dirZ;
        ent.f = dirF;
      end else begin
        r = refMul(bus.fp_X, bus.fp_Y, bus.r_mode);
        ent.z = r[31:0];
        ent.f = r[36:32];
      end
      ent.tag = bus.in_tag;
      expQ.push_back(ent);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out_valid", 64'(bus.out_valid), 64'(0));
      end else begin
        ent = expQ.pop_front();
        checkOutput("result_z", 64'(bus.fp_Z), 64'(ent.z));
        checkOutput("result_flags", 64'(flags), 64'(ent.f));
        checkOutput("result_tag", 64'(bus.out_tag), 64'(ent.tag));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                               input logic [3:0] tag, output int tries);
    bus.in_valid = 1'b1;
    bus.fp_X     = x;
    bus.fp_Y     = y;
    bus.r_mode   = rm;
    bus.in_tag   = tag;
    tries = 0;
    do begin
      runCycle();
      tries++;
    end while (!accepted && tries < 50);
    if (!accepted) checkOutput("accept_timeout", 64'(accepted), 64'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic applyDirected(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                               input logic [3:0] tag, input logic [31:0] z, input logic [4:0] f,
                               output int tries);
    useDirected = 1'b1;
    dirZ = z;
    dirF = f;
    applyStimulus(x, y, rm, tag, tries);
    useDirected = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.in_valid = 1'b0;
    n = 0;
    while (expQ.size() > 0 && n < 200) begin
      runCycle();
      n++;
    end
    checkOutput("drain_empty", 64'(expQ.size()), 64'(0));
  endtask

  initial begin
    int tries;
    int lat;
    int base;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.fp_X      = '0;
    bus.fp_Y      = '0;
    bus.r_mode    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    #3;
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'(1));
    checkOutput("reset_fp_Z", 64'(bus.fp_Z), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic product and exact three-cycle latency
    applyDirected(32'h40400000, 32'h40400000, 3'b001, 4'd5, 32'h41100000, 5'b00000, tries);
    lat = 0;
    do begin
      runCycle();
      lat++;
    end while (!sawOutValid && lat < 10);
    checkOutput("latency", 64'(lat), 64'(3));
    drain();

    // Overflow, underflow, NaN and rounding corners, back to back with mixed modes
    applyDirected(32'h7F000000, 32'h7F000000, 3'b001, 4'd1, 32'h7F7FFFFF, 5'b10000, tries);
    applyDirected(32'h7F000000, 32'h7F000000, 3'b000, 4'd2, 32'h7F800000, 5'b10010, tries);
    applyDirected(32'h20000000, 32'h1F800000, 3'b001, 4'd3, 32'h00000000, 5'b01100, tries);
    applyDirected(32'h00000000, 32'hFF800000, 3'b000, 4'd4, 32'h7FC00000, 5'b00001, tries);
    applyDirected(32'h3F800001, 32'h3F800001, 3'b000, 4'd6, 32'h3F800002, 5'b00000, tries);
    applyDirected(32'h3F800001, 32'h3F800001, 3'b011, 4'd7, 32'h3F800003, 5'b00000, tries);
    applyDirected(32'hBF800001, 32'h3F800001, 3'b010, 4'd8, 32'hBF800003, 5'b00000, tries);
    drain();

    // Five back-to-back operations with the consumer stalling mid-stream
    base    = cyc;
    stallLo = base + 4;
    stallHi = base + 6;
    for (int i = 0; i < 5; i++)
      applyStimulus(genOperand(), genOperand(), 3'($urandom), 4'(i + 9), tries);
    drain();
    stallLo = -1;
    stallHi = -1;

    // Random traffic with random back-pressure and gaps
    randReady = 1'b1;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(genOperand(), genOperand(), 3'($urandom), 4'($urandom), tries);
      if ($urandom_range(0, 3) == 0) runCycle();
    end
    drain();
    randReady = 1'b0;

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++)
      applyStimulus(genOperand(), genOperand(), 3'($urandom), 4'(i), tries);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("async_rst_fp_Z", 64'(bus.fp_Z), 64'(0));
    checkOutput("async_rst_flags", 64'({bus.ovrf, bus.udrf, bus.zer, bus.inf, bus.nan}), 64'(0));
    checkOutput("async_rst_tag", 64'(bus.out_tag), 64'(0));
    checkOutput("async_rst_in_ready", 64'(bus.in_ready), 64'(1));
    expQ.delete();
    stalledPrev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyDirected(32'h40400000, 32'hC0400000, 3'b000, 4'd12, 32'hC1100000, 5'b00000, tries);
    checkOutput("first_accept_tries", 64'(tries), 64'(1));
    drain();
    repeat (8) runCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 SHALL have parameter FRC_W, default 23, meaning stored fraction field width; the operand width is W = 1+EXP_W+FRC_W.
REQ-003 SHALL have parameter TAG_W, default 4, meaning the width of the opaque tag passed from input to output.
REQ-004 SHALL have ports, one per line: clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block accepts the pair this cycle.
- fp_X, fp_Y  in  W  operands.
- r_mode  in  3  rounding mode, sampled with the operands.
- in_tag  in  TAG_W  user tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- fp_Z  out  W  product.
- out_tag  out  TAG_W  tag of the product.
- ovrf, udrf, zer, inf, nan  out  1 each  exception flags, qualified by out_valid.

Function
REQ-005 SHALL be a 3-stage pipeline: S1 unpack and significand multiply; S2 normalise and round; S3 exponent, exceptions and pack.
REQ-006 SHALL have a latency of exactly 3 cycles from an accepted input to out_valid when no stall occurs.
REQ-007 SHALL sustain a throughput of one operation per cycle.
REQ-008 SHALL compute a global advance as en = !out_valid || out_ready, and SHALL drive in_ready = en.
REQ-009 SHALL treat a transfer as valid&&ready on either side.
REQ-010 SHALL hold every stage register, including valid bits, data, tag and r_mode, unchanged while en=0.
- While stalled, fp_Z, the flags and out_tag SHALL remain stable.
REQ-011 SHALL insert a bubble into S1 (S1 valid=0) when en=1 and in_valid=0.
- Empty stages SHALL advance without blocking.
REQ-012 SHALL carry r_mode and in_tag alongside each operation, so that mode changes between back-to-back operations take effect per operation.
REQ-013 SHALL form significands as {hidden,frac}, where hidden=1 iff the exponent field is non-zero.
- The product SHALL be 2*(FRC_W+1) bits wide.
REQ-014 SHALL flush subnormal inputs: an input with exponent field 0 SHALL be treated as signed zero.
REQ-015 SHALL normalise the product: if product MSB=1, it SHALL set norm_n=1 and keep the product; otherwise it SHALL shift left by 1.
- The kept fraction SHALL be FRC_W bits.
- G SHALL be the next bit, R the bit after G, and S the OR of all lower bits.
REQ-016 SHALL round per r_mode, with inc defined as follows:
- 000 RNE: inc = G&&(R||S||lsb).
- 001 RTZ: inc = 0.
- 010 RDN: inc = sign&&(G||R||S).
- 011 RUP: inc = !sign&&(G||R||S).
- 100 RMM: inc = G.
- 101–111: SHALL behave as RNE.
REQ-017 SHALL set norm_r=1 when rounding carries out of the significand, and SHALL then use fraction 0 with exponent +1.
REQ-018 SHALL compute the sign as fp_X[W-1]^fp_Y[W-1] for all results, including zero and inf. NaN is excepted.
REQ-019 SHALL compute the biased exponent as eX+eY-BIAS+norm_n+norm_r.
- BIAS SHALL be 2^(EXP_W-1)-1.
- This sum SHALL be computed at EXP_W+2 bits signed, so that no wrap can occur.
REQ-020 SHALL flag overflow when the exponent is >= 2^EXP_W-1: ovrf=1 and inf=1.
- fp_Z SHALL be inf for RNE/RMM, RUP with positive sign, and RDN with negative sign.
- Otherwise fp_Z SHALL be the maximum finite value with the result sign, and inf SHALL then be 0.
REQ-021 SHALL flag underflow when the exponent is <= 0 with both inputs non-zero: udrf=1 and zer=1, and fp_Z SHALL be signed zero (no subnormal output).
REQ-022 SHALL handle special operands:
- Either operand NaN, or inf×zero (including a flushed subnormal): nan=1, fp_Z = canonical quiet NaN (sign 0, exponent all-ones, fraction MSB only), all other flags 0.
- Inf×finite non-zero or inf×inf: inf=1, fp_Z = signed inf, ovrf=0.
- Zero×finite: zer=1, fp_Z = signed zero.
REQ-023 SHALL give special-operand results priority over the overflow and underflow computation.
REQ-024 SHALL have at most one of nan, inf and zer set at a time.

Reset
REQ-025 SHALL, on rst_n=0, immediately clear all stage valid bits, out_valid, fp_Z, out_tag and all flags to 0, regardless of the clock.
REQ-026 SHALL discard any operations in flight at reset; no result for them SHALL ever appear.
REQ-027 SHALL drive in_ready=1 during and after reset, since out_valid=0.
REQ-028 SHALL accept an input on the first rising edge after rst_n rises.

Verification
REQ-029 SHALL pass this scenario: 0x40400000×0x40400000, r_mode=001, tag=5 -> three cycles later out_valid=1, fp_Z=0x41100000, out_tag=5, all flags 0.
REQ-030 SHALL pass this scenario: 0x7F000000×0x7F000000, RTZ -> fp_Z=0x7F7FFFFF, ovrf=1, inf=0; the same operands in RNE -> fp_Z=0x7F800000, ovrf=1, inf=1.
REQ-031 SHALL pass this scenario: 0x20000000×0x1F800000, RTZ -> fp_Z=0x00000000, udrf=1, zer=1; and 0x00000000×0xFF800000 -> fp_Z=0x7FC00000, nan=1.
REQ-032 SHALL pass this scenario: 0x3F800001×0x3F800001 in RNE -> fp_Z=0x3F800002; in RUP -> 0x3F800003; in RDN with X sign set -> 0xBF800003.
REQ-033 SHALL pass this scenario: five back-to-back inputs with out_ready low for cycles 4–6 -> in_ready=0 while out_valid&&!out_ready, outputs stable, all five results delivered in order with correct tags, none lost or duplicated.
REQ-034 SHALL pass this scenario: assert rst_n=0 with three operations in flight -> out_valid=0 at once, and after release no stale result appears.
